// File: rtl/mips16_ifu.sv
// Instruction fetch unit: one request outstanding, ack-to-valid 1 cycle, next fetch issued 1 cycle after consume.
// Decode backpressure holds the instruction with no request; flush redirects, draining an in-flight access first.
module mips16_ifu #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [2:0]  opcode,
    output logic [15:0] pc_p2,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic        jr,
    input  logic [15:0] rs_data,
    input  logic        flush,
    input  logic [15:0] flush_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_req_addr;
    logic [15:0] r_instr;
    logic [15:0] r_pc_p2;
    logic        r_valid;
    logic        r_req;

    logic [15:0] w_next_pc;
    logic [15:0] w_flush_pc;
    logic [15:0] w_br_off;
    logic        w_unused;

    assign w_flush_pc = {flush_pc[15:1], 1'b0};
    assign w_br_off   = {{8{r_instr[6]}}, r_instr[6:0], 1'b0};
    assign w_unused   = rs_data[0] ^ flush_pc[0];

    always_comb begin
        w_next_pc = r_pc_p2;
        if (jr) begin
            w_next_pc = {rs_data[15:1], 1'b0};
        end else if (jump) begin
            w_next_pc = {r_pc_p2[15:14], r_instr[12:0], 1'b0};
        end else if (branch && alu_zero) begin
            w_next_pc = r_pc_p2 + w_br_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_instr    <= 16'h0000;
            r_pc_p2    <= 16'h0000;
            r_valid    <= 1'b0;
            r_req      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                    r_req   <= 1'b1;
                    if (flush) begin
                        r_pc       <= w_flush_pc;
                        r_req_addr <= w_flush_pc;
                    end else begin
                        r_req_addr <= r_pc;
                    end
                end
                REQ: begin
                    if (flush) begin
                        // Without an ack the old access is still in flight and must finish at its own address
                        r_pc <= w_flush_pc;
                        if (imem_ack) begin
                            r_req_addr <= w_flush_pc;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_pc_p2 <= r_pc + 16'd2;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= VALID;
                    end
                end
                VALID: begin
                    if (flush) begin
                        r_pc       <= w_flush_pc;
                        r_req_addr <= w_flush_pc;
                        r_valid    <= 1'b0;
                        r_req      <= 1'b1;
                        r_state    <= REQ;
                    end else if (instr_ready) begin
                        r_pc       <= w_next_pc;
                        r_req_addr <= w_next_pc;
                        r_valid    <= 1'b0;
                        r_req      <= 1'b1;
                        r_state    <= REQ;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        r_pc <= w_flush_pc;
                    end
                    if (imem_ack) begin
                        r_state    <= REQ;
                        r_req_addr <= flush ? w_flush_pc : r_pc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_req_addr;
    assign instr       = r_instr;
    assign opcode      = r_instr[15:13];
    assign pc_p2       = r_pc_p2;
    assign instr_valid = r_valid;

endmodule
